// File: rtl/aes256_round_ctrl.sv
// Iterative AES round sequencer: owns the 128-bit state and the round counter, and
// drives one external combinational round datapath per cycle. Ciphertext leaves via valid/ready.
module aes256_round_ctrl #(
  parameter int unsigned NR = 14  // 10, 12 or 14 rounds
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] in_data_i,
  output logic [3:0]   rk_idx_o,
  input  logic [127:0] rk_i,
  input  logic         rk_valid_i,
  output logic [127:0] dp_in_o,
  output logic         dp_last_o,
  input  logic [127:0] dp_out_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] out_data_o,
  output logic         busy_o,
  output logic [3:0]   round_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [3:0] NR_L = 4'(NR);

  state_e       fsm_q, fsm_d;
  logic [127:0] data_q, data_d;
  logic [3:0]   round_q, round_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q   <= IDLE;
      data_q  <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      data_q  <= data_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    data_d      = data_q;
    round_d     = round_q;
    in_ready_o  = 1'b0;
    rk_idx_o    = round_q;
    dp_last_o   = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    case (fsm_q)
      IDLE: begin
        rk_idx_o   = 4'd0;
        // Acceptance needs round key 0 for the initial AddRoundKey.
        in_ready_o = rk_valid_i;
        if (in_valid_i && rk_valid_i) begin
          data_d  = in_data_i ^ rk_i;
          round_d = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        busy_o    = 1'b1;
        rk_idx_o  = round_q;
        dp_last_o = (round_q == NR_L);
        if (rk_valid_i) begin
          data_d = dp_out_i;
          if (round_q == NR_L) begin
            fsm_d = DONE;
          end else begin
            round_d = round_q + 4'd1;
          end
        end
      end
      DONE: begin
        busy_o      = 1'b1;
        out_valid_o = 1'b1;
        rk_idx_o    = NR_L;
        if (out_ready_i) begin
          fsm_d   = IDLE;
          round_d = 4'd0;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign dp_in_o    = data_q;
  assign out_data_o = data_q;
  assign round_o    = round_q;

endmodule
